ttt_engine: RTL and testbench
=============================

# ttt_engine

Parametrised N×N, K-in-a-row game engine for two players. It owns board storage, turn enforcement, move validation, win and draw detection, and per-player series scores. It sits between the player input logic and the LED/display logic as a single-block datapath plus control. The first mover alternates each game.

## Interface
- N, 3, board side length; legal range 3..8.
- K, 3, run length that wins; legal range 3..N.
- SCORE_W, 4, width of each series-score counter.
- RW, derived as max(1, clog2(N)); width of the row and column fields.
- MW, derived as clog2(N*N+1); width of the move counter.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- new_game  in  1  synchronous; clears the board and starts the next game.
- move_valid  in  1  move request.
- move_player  in  1  0 = player 1, 1 = player 2.
- move_row  in  RW  target row.
- move_col  in  RW  target column.
- move_ready  out  1  engine can take a move this cycle.
- move_err  out  1  one-cycle pulse when an accepted move is illegal.
- p1_board  out  N*N  player 1 cells; bit index is row*N+col.
- p2_board  out  N*N  player 2 cells; same indexing.
- turn  out  1  player expected to move next.
- moves  out  MW  number of legal moves placed this game.
- p1win  out  1  player 1 won the current game.
- p2win  out  1  player 2 won the current game.
- draw  out  1  board full with no winner.
- done  out  1  game over.
- p1_score  out  SCORE_W  player 1 series wins; saturating.
- p2_score  out  SCORE_W  player 2 series wins; saturating.

## Operation
- States are PLAY, CHECK and OVER. Reset enters PLAY.
- Reset values: both boards 0, turn 0, moves 0, all flags 0, both scores 0, move_err 0, first-mover register 0.
- A move is accepted when move_valid && move_ready. move_ready is 1 in PLAY and OVER, and 0 in CHECK and in any cycle where new_game is 1.
- An accepted move is legal only if all of the following hold:
  - the state is PLAY;
  - move_player == turn;
  - move_row < N and move_col < N;
  - the target cell is set in neither board.
- Legal move: on the next edge, set the cell in the mover's board, increment moves, and go to CHECK.
- Illegal move: move_err pulses on the next edge. No other state changes.
- CHECK takes exactly one cycle and evaluates only the mover's board. A win is any K consecutive set cells in a row, column, diagonal or anti-diagonal. Outcomes:
  - Win: set p1win or p2win, increment the mover's score, saturating at 2^SCORE_W−1, then go to OVER.
  - No win and moves == N*N: set draw, then go to OVER.
  - Otherwise: toggle turn, then go to PLAY.
- OVER: done = 1 and flags hold. Every accepted move is rejected with move_err.
- new_game works from any state and has priority over a simultaneous move; that move gets no err. On the next edge:
  - boards, moves and flags clear;
  - the first-mover register toggles and turn loads its new value;
  - the state becomes PLAY;
  - scores are kept.
- rst in any state, including mid-CHECK, returns everything to its reset values immediately. Scores are cleared only by rst.
- p1win, p2win and draw are mutually exclusive. done = p1win | p2win | draw.

## Timing
- Accept edge E: board bit and moves update at E, and the state becomes CHECK.
- Result: flags and score update at E+1. Either done rises or turn toggles at E+1, and move_ready returns at E+1.
- Maximum legal move rate is one per 2 cycles.
- move_err is registered. It is high for exactly the one cycle following the accept edge.
- A held move_valid during CHECK is simply not accepted until move_ready returns. It is not an error.
- All outputs are registered. Win detection is combinational from board registers into the CHECK-state update.

## Test plan
- Test 1, N=3, K=3, row win for player 1:
  - Moves: P1(0,0), P2(1,0), P1(0,1), P2(1,1), P1(0,2).
  - One cycle after the last accept edge: p1win=1, done=1, p1_board=9'h007, p2_board=9'h018, p1_score=1, moves=5.
- Test 2, N=3, draw:
  - Moves: P1(0,0), P2(0,1), P1(0,2), P2(1,1), P1(1,0), P2(1,2), P1(2,1), P2(2,0), P1(2,2).
  - Required: draw=1, no win flags, moves=9, scores unchanged.
- Test 3, illegal moves:
  - Each of the following gives a one-cycle move_err with board and turn unchanged: P2 moving on P1's turn, a move to an occupied cell, row=3 with N=3, and any move while done=1.
  - A move held during CHECK gives no err.
- Test 4, N=5, K=4, anti-diagonal:
  - P2 occupies (0,4), (1,3), (2,2), (3,1) while P1 plays non-winning cells.
  - Required: p2win=1 only after the fourth P2 cell. With K=4, three in a row gives no win.
- Test 5, new_game and score saturation:
  - new_game after game 1 gives turn=1, board cleared and scores kept.
  - A move in the same cycle as new_game is ignored with no err.
  - With SCORE_W=2, four P1 wins leave p1_score=3.
- Test 6, reset mid-operation:
  - Assert rst in the CHECK cycle after a would-be winning move.
  - Required: all outputs 0 immediately, state PLAY, scores 0, and the next P1 move is accepted.

Source files
------------

// File: rtl/ttt_engine.sv
`default_nettype none
// ============================================================================
// ttt_engine : N x N, K-in-a-row two-player game engine with series scoring
// Revision   : 1.0
// ============================================================================
module ttt_engine #(
   parameter  int N       = 3,
   parameter  int K       = 3,
   parameter  int SCORE_W = 4,
   localparam int RW      = ($clog2(N) > 1) ? $clog2(N) : 1,
   localparam int MW      = $clog2(N*N+1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               new_game,
   input  logic               move_valid,
   input  logic               move_player,
   input  logic [RW-1:0]      move_row,
   input  logic [RW-1:0]      move_col,
   output logic               move_ready,
   output logic               move_err,
   output logic [N*N-1:0]     p1_board,
   output logic [N*N-1:0]     p2_board,
   output logic               turn,
   output logic [MW-1:0]      moves,
   output logic               p1win,
   output logic               p2win,
   output logic               draw,
   output logic               done,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score
);

   localparam int             c_cells = N*N;
   localparam logic [N*N-1:0] c_one   = {{(N*N-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      PLAY  = 2'd0,
      CHECK = 2'd1,
      OVER  = 2'd2
   } state_t;

   state_t               r_state;
   logic                 r_first;
   logic                 r_turn;
   logic                 r_err;
   logic [N*N-1:0]       r_p1_board;
   logic [N*N-1:0]       r_p2_board;
   logic [MW-1:0]        r_moves;
   logic                 r_p1win;
   logic                 r_p2win;
   logic                 r_draw;
   logic                 r_done;
   logic [SCORE_W-1:0]   r_p1_score;
   logic [SCORE_W-1:0]   r_p2_score;

   logic [N*N-1:0]       w_cell;
   logic [N*N-1:0]       w_mover_board;
   logic                 w_in_range;
   logic                 w_free;
   logic                 w_accept;
   logic                 w_legal;
   logic                 w_win;

   // Scans every K-long line in all four directions; only legal start cells are visited.
   function automatic logic has_run(input logic [N*N-1:0] b);
      logic hit;
      logic run;
      hit = 1'b0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c <= N-K; c++) begin
            run = 1'b1;
            for (int k = 0; k < K; k++) run = run & b[r*N + c + k];
            hit = hit | run;
         end
      for (int r = 0; r <= N-K; r++)
         for (int c = 0; c < N; c++) begin
            run = 1'b1;
            for (int k = 0; k < K; k++) run = run & b[(r+k)*N + c];
            hit = hit | run;
         end
      for (int r = 0; r <= N-K; r++)
         for (int c = 0; c <= N-K; c++) begin
            run = 1'b1;
            for (int k = 0; k < K; k++) run = run & b[(r+k)*N + c + k];
            hit = hit | run;
         end
      for (int r = 0; r <= N-K; r++)
         for (int c = K-1; c < N; c++) begin
            run = 1'b1;
            for (int k = 0; k < K; k++) run = run & b[(r+k)*N + c - k];
            hit = hit | run;
         end
      return hit;
   endfunction

   assign w_in_range    = (32'(move_row) < N) && (32'(move_col) < N);
   assign w_cell        = c_one << (32'(move_row)*N + 32'(move_col));
   assign w_free        = ~|(w_cell & (r_p1_board | r_p2_board));
   assign move_ready    = (r_state != CHECK) && !new_game;
   assign w_accept      = move_valid && move_ready;
   assign w_legal       = (r_state == PLAY) && (move_player == r_turn) && w_in_range && w_free;
   // Only the player who just moved can have completed a line.
   assign w_mover_board = r_turn ? r_p2_board : r_p1_board;
   assign w_win         = has_run(w_mover_board);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= PLAY;
         r_first    <= 1'b0;
         r_turn     <= 1'b0;
         r_err      <= 1'b0;
         r_p1_board <= '0;
         r_p2_board <= '0;
         r_moves    <= '0;
         r_p1win    <= 1'b0;
         r_p2win    <= 1'b0;
         r_draw     <= 1'b0;
         r_done     <= 1'b0;
         r_p1_score <= '0;
         r_p2_score <= '0;
      end else begin
         r_err <= 1'b0;
         if (new_game) begin
            r_state    <= PLAY;
            r_first    <= ~r_first;
            r_turn     <= ~r_first;
            r_p1_board <= '0;
            r_p2_board <= '0;
            r_moves    <= '0;
            r_p1win    <= 1'b0;
            r_p2win    <= 1'b0;
            r_draw     <= 1'b0;
            r_done     <= 1'b0;
         end else begin
            case (r_state)
               PLAY, OVER: begin
                  if (w_accept) begin
                     if (w_legal) begin
                        if (move_player) r_p2_board <= r_p2_board | w_cell;
                        else             r_p1_board <= r_p1_board | w_cell;
                        r_moves <= r_moves + 1'b1;
                        r_state <= CHECK;
                     end else begin
                        r_err <= 1'b1;
                     end
                  end
               end
               CHECK: begin
                  if (w_win) begin
                     if (r_turn) begin
                        r_p2win <= 1'b1;
                        if (r_p2_score != '1) r_p2_score <= r_p2_score + 1'b1;
                     end else begin
                        r_p1win <= 1'b1;
                        if (r_p1_score != '1) r_p1_score <= r_p1_score + 1'b1;
                     end
                     r_done  <= 1'b1;
                     r_state <= OVER;
                  end else if (32'(r_moves) == c_cells) begin
                     r_draw  <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= OVER;
                  end else begin
                     r_turn  <= ~r_turn;
                     r_state <= PLAY;
                  end
               end
               default: r_state <= PLAY;
            endcase
         end
      end
   end

   assign move_err = r_err;
   assign p1_board = r_p1_board;
   assign p2_board = r_p2_board;
   assign turn     = r_turn;
   assign moves    = r_moves;
   assign p1win    = r_p1win;
   assign p2win    = r_p2win;
   assign draw     = r_draw;
   assign done     = r_done;
   assign p1_score = r_p1_score;
   assign p2_score = r_p2_score;

endmodule
`default_nettype wire

// File: tb/tb_ttt_engine.sv
`default_nettype none
// ============================================================================
// tb_ttt_engine : directed + random checks of two engine configurations
// Revision      : 1.0
// ============================================================================
module tb_ttt_engine;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, new_game, move_valid, move_player;
   logic [2:0] move_row, move_col;

   logic       rdy3, err3, turn3, w13, w23, dr3, dn3;
   logic [8:0] p1b3, p2b3;
   logic [3:0] mv3;
   logic [1:0] s13, s23;

   logic        rdy5, err5, turn5, w15, w25, dr5, dn5;
   logic [24:0] p1b5, p2b5;
   logic [4:0]  mv5;
   logic [3:0]  s15, s25;

   ttt_engine #(.N(3), .K(3), .SCORE_W(2)) dut3 (
      .clk(clk), .rst(rst), .new_game(new_game), .move_valid(move_valid),
      .move_player(move_player), .move_row(move_row[1:0]), .move_col(move_col[1:0]),
      .move_ready(rdy3), .move_err(err3), .p1_board(p1b3), .p2_board(p2b3),
      .turn(turn3), .moves(mv3), .p1win(w13), .p2win(w23), .draw(dr3), .done(dn3),
      .p1_score(s13), .p2_score(s23));

   ttt_engine #(.N(5), .K(4), .SCORE_W(4)) dut5 (
      .clk(clk), .rst(rst), .new_game(new_game), .move_valid(move_valid),
      .move_player(move_player), .move_row(move_row), .move_col(move_col),
      .move_ready(rdy5), .move_err(err5), .p1_board(p1b5), .p2_board(p2b5),
      .turn(turn5), .moves(mv5), .p1win(w15), .p2win(w25), .draw(dr5), .done(dn5),
      .p1_score(s15), .p2_score(s25));

   // Reference model: one game per configuration, board as a 2-D array of owners.
   int nn[2]   = '{3, 5};
   int kk[2]   = '{3, 4};
   int msk[2]  = '{3, 7};
   int smax[2] = '{3, 15};

   int brd[2][8][8];
   int mmoves[2], ms1[2], ms2[2], lr[2], lc[2];
   bit mturn[2], mfirst[2], mp1w[2], mp2w[2], mdraw[2], merr[2], mchk[2];

   int nasrt = 0;
   int nfail = 0;

   function automatic void model_clear(int d);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) brd[d][r][c] = 0;
      mmoves[d] = 0; mp1w[d] = 0; mp2w[d] = 0; mdraw[d] = 0; mchk[d] = 0;
   endfunction

   function automatic void model_reset(int d);
      model_clear(d);
      mturn[d] = 0; mfirst[d] = 0; ms1[d] = 0; ms2[d] = 0; merr[d] = 0;
   endfunction

   // Longest run through the last placed stone, counted outwards in both senses.
   function automatic bit makes_run(int d);
      int dr[4];
      int dc[4];
      int who, cnt, r, c;
      dr = '{0, 1, 1, 1};
      dc = '{1, 0, 1, -1};
      who = brd[d][lr[d]][lc[d]];
      for (int i = 0; i < 4; i++) begin
         cnt = 1;
         for (int s = -1; s <= 1; s += 2) begin
            r = lr[d] + s*dr[i];
            c = lc[d] + s*dc[i];
            while (r >= 0 && r < nn[d] && c >= 0 && c < nn[d]) begin
               if (brd[d][r][c] != who) break;
               cnt++;
               r += s*dr[i];
               c += s*dc[i];
            end
         end
         if (cnt >= kk[d]) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic void model_step(int d, bit ng, bit v, bit p, int r, int c);
      int rr, cc;
      rr = r & msk[d];
      cc = c & msk[d];
      merr[d] = 0;
      if (ng) begin
         model_clear(d);
         mfirst[d] = !mfirst[d];
         mturn[d]  = mfirst[d];
      end else if (mchk[d]) begin
         mchk[d] = 0;
         if (makes_run(d)) begin
            if (brd[d][lr[d]][lc[d]] == 1) begin
               mp1w[d] = 1;
               if (ms1[d] < smax[d]) ms1[d]++;
            end else begin
               mp2w[d] = 1;
               if (ms2[d] < smax[d]) ms2[d]++;
            end
         end else if (mmoves[d] == nn[d]*nn[d]) begin
            mdraw[d] = 1;
         end else begin
            mturn[d] = !mturn[d];
         end
      end else if (v) begin
         if (!(mp1w[d] || mp2w[d] || mdraw[d]) && p == mturn[d] &&
             rr < nn[d] && cc < nn[d] && brd[d][rr][cc] == 0) begin
            brd[d][rr][cc] = p ? 2 : 1;
            mmoves[d]++;
            lr[d] = rr;
            lc[d] = cc;
            mchk[d] = 1;
         end else begin
            merr[d] = 1;
         end
      end
   endfunction

   function automatic logic [63:0] exp_board(int d, int who);
      logic [63:0] v;
      v = '0;
      for (int r = 0; r < nn[d]; r++)
         for (int c = 0; c < nn[d]; c++)
            if (brd[d][r][c] == who) v[r*nn[d] + c] = 1'b1;
      return v;
   endfunction

   task automatic chk(string tag, int d, logic [63:0] obs, logic [63:0] exp);
      nasrt++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, d, obs, exp);
      end
   endtask

   task automatic check_all(int d);
      logic [63:0] a_p1, a_p2, a_mv, a_s1, a_s2;
      logic        a_turn, a_err;
      logic [3:0]  a_fl;
      if (d == 0) begin
         a_p1 = 64'(p1b3); a_p2 = 64'(p2b3); a_mv = 64'(mv3);
         a_s1 = 64'(s13);  a_s2 = 64'(s23);  a_turn = turn3; a_err = err3;
         a_fl = {w13, w23, dr3, dn3};
      end else begin
         a_p1 = 64'(p1b5); a_p2 = 64'(p2b5); a_mv = 64'(mv5);
         a_s1 = 64'(s15);  a_s2 = 64'(s25);  a_turn = turn5; a_err = err5;
         a_fl = {w15, w25, dr5, dn5};
      end
      chk("p1_board", d, a_p1, exp_board(d, 1));
      chk("p2_board", d, a_p2, exp_board(d, 2));
      chk("turn",     d, 64'(a_turn), 64'(mturn[d]));
      chk("moves",    d, a_mv, 64'(mmoves[d]));
      chk("flags",    d, 64'(a_fl), 64'({mp1w[d], mp2w[d], mdraw[d], mp1w[d] | mp2w[d] | mdraw[d]}));
      chk("move_err", d, 64'(a_err), 64'(merr[d]));
      chk("p1_score", d, a_s1, 64'(ms1[d]));
      chk("p2_score", d, a_s2, 64'(ms2[d]));
   endtask

   task automatic cycle(bit ng, bit v, bit p, int r, int c);
      new_game    = ng;
      move_valid  = v;
      move_player = p;
      move_row    = 3'(r);
      move_col    = 3'(c);
      #1;
      chk("move_ready", 0, 64'(rdy3), 64'(!mchk[0] && !ng));
      chk("move_ready", 1, 64'(rdy5), 64'(!mchk[1] && !ng));
      @(posedge clk);
      model_step(0, ng, v, p, r, c);
      model_step(1, ng, v, p, r, c);
      #1;
      check_all(0);
      check_all(1);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   // Accept edge followed by the evaluation cycle.
   task automatic mv(bit p, int r, int c);
      cycle(1'b0, 1'b1, p, r, c);
      idle();
   endtask

   task automatic mvt(int d, int r, int c);
      mv(mturn[d], r, c);
   endtask

   initial begin
      bit ng, v, p;
      int r, c;

      rst = 1'b1; new_game = 1'b0; move_valid = 1'b0; move_player = 1'b0;
      move_row = '0; move_col = '0;
      model_reset(0);
      model_reset(1);
      repeat (2) @(negedge clk);
      check_all(0);
      check_all(1);
      rst = 1'b0;

      // Row win for player 1 on the 3x3 board
      mv(0, 0, 0); mv(1, 1, 0); mv(0, 0, 1); mv(1, 1, 1); mv(0, 0, 2);
      chk("t1_p1b",   0, 64'(p1b3), 64'h007);
      chk("t1_p2b",   0, 64'(p2b3), 64'h018);
      chk("t1_flags", 0, 64'({w13, w23, dr3, dn3}), 64'b1001);
      chk("t1_score", 0, 64'(s13), 64'd1);
      chk("t1_moves", 0, 64'(mv3), 64'd5);

      // Illegal moves and a move held through the evaluation cycle
      cycle(1'b0, 1'b1, 1'b1, 2, 2);
      chk("t3_over_err", 0, 64'(err3), 64'd1);
      idle();
      cycle(1'b1, 1'b1, 1'b0, 2, 0);
      chk("t5_ng_err",  0, 64'(err3), 64'd0);
      chk("t5_turn",    0, 64'(turn3), 64'd1);
      chk("t5_board",   0, 64'({p1b3, p2b3}), 64'd0);
      chk("t5_score",   0, 64'(s13), 64'd1);
      cycle(1'b0, 1'b1, 1'b0, 0, 0);
      chk("t3_turn_err", 0, 64'(err3), 64'd1);
      idle();
      chk("t3_err_pulse", 0, 64'(err3), 64'd0);
      cycle(1'b0, 1'b1, 1'b1, 1, 1);
      cycle(1'b0, 1'b1, 1'b1, 1, 1);
      chk("t3_held_err", 0, 64'(err3), 64'd0);
      cycle(1'b0, 1'b1, 1'b1, 1, 1);
      idle();
      cycle(1'b0, 1'b1, 1'b0, 1, 1);
      chk("t3_occ_err", 0, 64'(err3), 64'd1);
      chk("t3_occ_p1b", 0, 64'(p1b3), 64'd0);
      idle();
      cycle(1'b0, 1'b1, 1'b0, 3, 0);
      chk("t3_row_err", 0, 64'(err3), 64'd1);
      idle();

      // Draw on the 3x3 board
      cycle(1'b1, 1'b0, 1'b0, 0, 0);
      chk("t2_turn", 0, 64'(turn3), 64'd0);
      mv(0, 0, 0); mv(1, 0, 1); mv(0, 0, 2); mv(1, 1, 1); mv(0, 1, 0);
      mv(1, 1, 2); mv(0, 2, 1); mv(1, 2, 0); mv(0, 2, 2);
      chk("t2_flags", 0, 64'({w13, w23, dr3, dn3}), 64'b0011);
      chk("t2_moves", 0, 64'(mv3), 64'd9);
      chk("t2_score", 0, 64'({s13, s23}), 64'b0100);

      // Anti-diagonal for player 2 on the 5x5, K=4 board
      cycle(1'b1, 1'b0, 1'b0, 0, 0);
      chk("t4_turn", 1, 64'(turn5), 64'd1);
      mv(1, 0, 4); mv(0, 0, 0); mv(1, 1, 3); mv(0, 0, 1); mv(1, 2, 2);
      chk("t4_three", 1, 64'(w25), 64'd0);
      mv(0, 4, 4); mv(1, 3, 1);
      chk("t4_win",   1, 64'({w15, w25, dr5, dn5}), 64'b0101);
      chk("t4_score", 1, 64'(s25), 64'd1);

      // Repeated player-1 wins saturate the 2-bit score
      for (int g = 0; g < 4; g++) begin
         cycle(1'b1, 1'b0, 1'b0, 0, 0);
         if (mturn[0] == 1'b0) begin
            mvt(0, 0, 0); mvt(0, 1, 0); mvt(0, 0, 1); mvt(0, 1, 1); mvt(0, 0, 2);
         end else begin
            mvt(0, 1, 0); mvt(0, 0, 0); mvt(0, 1, 1); mvt(0, 0, 1); mvt(0, 2, 2); mvt(0, 0, 2);
         end
      end
      chk("t5_sat", 0, 64'(s13), 64'd3);

      // Reset during the evaluation cycle of a winning move
      cycle(1'b1, 1'b0, 1'b0, 0, 0);
      mvt(0, 0, 0); mvt(0, 1, 0); mvt(0, 0, 1); mvt(0, 1, 1);
      cycle(1'b0, 1'b1, mturn[0], 0, 2);
      rst = 1'b1;
      #1;
      model_reset(0);
      model_reset(1);
      check_all(0);
      check_all(1);
      chk("t6_all", 0, 64'({p1b3, p2b3, turn3, mv3, w13, w23, dr3, dn3, err3, s13, s23}), 64'd0);
      #1;
      rst = 1'b0;
      cycle(1'b0, 1'b1, 1'b0, 2, 2);
      chk("t6_accept", 0, 64'(p1b3), 64'h100);
      idle();

      // Random play on both boards
      for (int i = 0; i < 400; i++) begin
         ng = ($urandom_range(0, 24) == 0);
         v  = ($urandom_range(0, 3) != 0);
         p  = ($urandom_range(0, 4) == 0) ? 1'($urandom_range(0, 1)) : mturn[$urandom_range(0, 1)];
         r  = $urandom_range(0, 5);
         c  = $urandom_range(0, 5);
         cycle(ng, v, p, r, c);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
      $finish;
   end

endmodule
`default_nettype wire
